// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter: takes a WIDTH-bit word over valid/ready and
// shifts it out one bit per clock with a registered complementary pair and frame markers.
module piso_shift_tx #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             sdo,
    output logic             sdo_bar,
    output logic             sdo_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy
);

    // Handshake: a word is taken on any posedge where load_valid && load_ready.
    // load_ready is high while idle and during the last bit of a frame, so a
    // word offered then is sent back-to-back with no gap cycle.

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic             sdo_n;
    logic             sdo_valid_n;
    logic             frame_start_n;
    logic             frame_done_n;
    logic             accept;
    logic             last_bit;
    logic             first_bit;

    assign last_bit   = (state == SHIFT) && (cnt == LAST);
    assign load_ready = (state == IDLE) || last_bit;
    assign accept     = load_valid && load_ready;
    assign busy       = (state == SHIFT);
    assign first_bit  = LSB_FIRST ? load_data[0] : load_data[WIDTH-1];

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        sreg_n        = sreg;
        sdo_n         = sdo;
        sdo_valid_n   = sdo_valid;
        frame_start_n = frame_start;
        frame_done_n  = frame_done;

        if (accept) begin
            state_n       = SHIFT;
            cnt_n         = '0;
            sreg_n        = load_data;
            sdo_n         = first_bit;
            sdo_valid_n   = 1'b1;
            frame_start_n = 1'b1;
            frame_done_n  = 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    if (!last_bit) begin
                        // The bit on sdo has already left sreg's edge position; the
                        // next one sits one place further in, then the register moves up.
                        cnt_n         = cnt + CNT_W'(1);
                        frame_start_n = 1'b0;
                        frame_done_n  = ((cnt + CNT_W'(1)) == LAST);
                        if (LSB_FIRST) begin
                            sdo_n  = sreg[1];
                            sreg_n = sreg >> 1;
                        end else begin
                            sdo_n  = sreg[WIDTH-2];
                            sreg_n = sreg << 1;
                        end
                    end else begin
                        state_n       = IDLE;
                        sdo_n         = 1'b0;
                        sdo_valid_n   = 1'b0;
                        frame_start_n = 1'b0;
                        frame_done_n  = 1'b0;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // sdo_bar is taken from the same next value as sdo so the pair never disagrees.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            sreg        <= '0;
            sdo         <= 1'b0;
            sdo_bar     <= 1'b1;
            sdo_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            cnt         <= cnt_n;
            sreg        <= sreg_n;
            sdo         <= sdo_n;
            sdo_bar     <= ~sdo_n;
            sdo_valid   <= sdo_valid_n;
            frame_start <= frame_start_n;
            frame_done  <= frame_done_n;
        end
    end

endmodule
